decode_pipe_controller: RTL

Sequencing controller for the three-stage decode pipeline (format scan, format-specific decode, output mux). It tracks per-stage valid bits and drives the shared stall and per-stage enables from downstream backpressure. It also assigns monotonically increasing major instruction IDs at fetch acceptance, detects instructions the format scanner cannot classify, and handles pipeline flushes. It sits between the fetch unit, the decode unit and the downstream consumer.

---
 rtl/decode_pipe_controller_if.sv | 38 +++
 rtl/decode_pipe_controller.sv | 106 ++++++++++
 2 files changed

// File: rtl/decode_pipe_controller_if.sv
// ============================================================================
// decode_pipe_controller_if : handshake/status bundle between the decode
//                             pipeline controller and its environment
// Revision: 1.0
// ============================================================================
`default_nettype none

interface decode_pipe_controller_if #(
  parameter int instructionCounterWidth = 64,
  parameter int formatWidth             = 25
);
  logic                               fetchValid_i;
  logic                               fetchReady_o;
  logic                               flush_i;
  logic                               downstreamReady_i;
  logic [formatWidth-1:0]             stage1Format_i;
  logic [2:0]                         stageEnable_o;
  logic                               stall_o;
  logic [instructionCounterWidth-1:0] majId_o;
  logic                               decodeValid_o;
  logic                               illegal_o;
  logic [instructionCounterWidth-1:0] illegalMajId_o;
  logic [1:0]                         inflight_o;

  modport master (
    input  fetchValid_i, flush_i, downstreamReady_i, stage1Format_i,
    output fetchReady_o, stageEnable_o, stall_o, majId_o, decodeValid_o,
           illegal_o, illegalMajId_o, inflight_o
  );

  modport slave (
    output fetchValid_i, flush_i, downstreamReady_i, stage1Format_i,
    input  fetchReady_o, stageEnable_o, stall_o, majId_o, decodeValid_o,
           illegal_o, illegalMajId_o, inflight_o
  );
endinterface

`default_nettype wire

// File: rtl/decode_pipe_controller.sv
// ============================================================================
// decode_pipe_controller : valid/stall/enable sequencing for the three-stage
//                          decode pipeline, major-ID allocation, illegal halt
// Revision: 1.0
// ============================================================================
`default_nettype none

module decode_pipe_controller #(
  parameter int instructionCounterWidth = 64,
  parameter int formatWidth             = 25
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  decode_pipe_controller_if.master bus
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic v1_q, v1_d;
  logic v2_q, v2_d;
  logic v3_q, v3_d;
  logic [instructionCounterWidth-1:0] id1_q, id1_d;
  logic [instructionCounterWidth-1:0] maj_ctr_q, maj_ctr_d;
  logic [instructionCounterWidth-1:0] illegal_maj_id_q, illegal_maj_id_d;

  logic w_advance;
  logic w_fetch_ready;
  logic w_accept;
  logic w_illegal_det;
  logic w_illegal_take;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q          <= ST_RUN;
      v1_q             <= 1'b0;
      v2_q             <= 1'b0;
      v3_q             <= 1'b0;
      id1_q            <= '0;
      maj_ctr_q        <= '0;
      illegal_maj_id_q <= '0;
    end else begin
      state_q          <= state_d;
      v1_q             <= v1_d;
      v2_q             <= v2_d;
      v3_q             <= v3_d;
      id1_q            <= id1_d;
      maj_ctr_q        <= maj_ctr_d;
      illegal_maj_id_q <= illegal_maj_id_d;
    end
  end

  always_comb begin
    w_advance      = !v3_q || bus.downstreamReady_i;
    w_fetch_ready  = w_advance && !bus.flush_i && (state_q == ST_RUN) && !reset_i;
    w_accept       = bus.fetchValid_i && w_fetch_ready;
    w_illegal_det  = v1_q && (bus.stage1Format_i == {formatWidth{1'b0}});
    w_illegal_take = w_illegal_det && w_advance && !bus.flush_i;

    state_d          = state_q;
    v1_d             = v1_q;
    v2_d             = v2_q;
    v3_d             = v3_q;
    id1_d            = id1_q;
    maj_ctr_d        = maj_ctr_q;
    illegal_maj_id_d = illegal_maj_id_q;

    // Flush wins over everything; the ID counter deliberately survives it.
    if (bus.flush_i) begin
      v1_d    = 1'b0;
      v2_d    = 1'b0;
      v3_d    = 1'b0;
      state_d = ST_RUN;
    end else if (w_advance) begin
      v3_d = v2_q;
      v2_d = v1_q && !w_illegal_det;
      v1_d = w_accept;
      if (w_accept) begin
        id1_d     = maj_ctr_q;
        maj_ctr_d = maj_ctr_q + instructionCounterWidth'(1);
      end
      if (w_illegal_take) begin
        illegal_maj_id_d = id1_q;
        state_d          = ST_HALT;
      end
    end
  end

  assign bus.fetchReady_o     = w_fetch_ready;
  assign bus.stall_o          = !w_advance && !reset_i;
  assign bus.stageEnable_o[0] = w_accept;
  assign bus.stageEnable_o[1] = v1_q && w_advance && !w_illegal_det && !bus.flush_i && !reset_i;
  assign bus.stageEnable_o[2] = v2_q && w_advance && !bus.flush_i && !reset_i;
  assign bus.majId_o          = maj_ctr_q;
  assign bus.decodeValid_o    = v3_q && !bus.flush_i && !reset_i;
  assign bus.illegal_o        = w_illegal_take && !reset_i;
  assign bus.illegalMajId_o   = illegal_maj_id_q;
  assign bus.inflight_o       = 2'(v1_q) + 2'(v2_q) + 2'(v3_q);

endmodule

`default_nettype wire
